// File: rtl/field_unit_arbiter.sv
// Round-robin arbiter sharing one edge-triggered two-operand field unit among NREQ requesters.
// Optional BUSY watchdog enabled by defining FIELD_ARB_TIMEOUT_EN.
`ifndef FIELD_ARITH_DEFS_PKG
`define FIELD_ARITH_DEFS_PKG
package field_arith_defs;
  localparam int F_NBITS = 32;
endpackage
`endif

module field_unit_arbiter
  import field_arith_defs::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*F_NBITS-1:0] a_in,
  input  logic [NREQ*F_NBITS-1:0] b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done_pulse,
  output logic [F_NBITS-1:0]      c,
  output logic                    busy,
  output logic                    err,
  output logic                    unit_en,
  output logic [F_NBITS-1:0]      unit_a,
  output logic [F_NBITS-1:0]      unit_b,
  input  logic                    unit_ready_pulse,
  input  logic [F_NBITS-1:0]      unit_c
);

  localparam int PTR_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_param_check
    $error("field_unit_arbiter: NREQ must be 2..16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic             win_vld;
  logic             to_hit;

  function automatic logic [PTR_W-1:0] idx_wrap(input logic [PTR_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  // Scan downwards so the lowest offset from ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[idx_wrap(ptr, k)]) begin
        win_vld = 1'b1;
        win_idx = idx_wrap(ptr, k);
      end
    end
  end

`ifdef FIELD_ARB_TIMEOUT_EN
  localparam int TO_RAW = $clog2(TIMEOUT + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)              to_cnt <= '0;
    else if (state != BUSY) to_cnt <= '0;
    else                    to_cnt <= to_cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th BUSY cycle.
  assign to_hit = (state == BUSY) && (to_cnt == TO_W'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      done_pulse <= '0;
      c          <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      unit_en    <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_pulse <= '0;
          err        <= 1'b0;
          unit_en    <= 1'b0;
          gnt        <= '0;
          if (win_vld) begin
            unit_a  <= a_in[win_idx*F_NBITS +: F_NBITS];
            unit_b  <= b_in[win_idx*F_NBITS +: F_NBITS];
            gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            unit_en <= 1'b1;
            busy    <= 1'b1;
            ptr     <= idx_wrap(win_idx, 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (unit_ready_pulse) begin
            c          <= unit_c;
            done_pulse <= gnt;
            unit_en    <= 1'b0;
            state      <= DONE;
          end else if (to_hit) begin
            done_pulse <= gnt;
            err        <= 1'b1;
            unit_en    <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          done_pulse <= '0;
          gnt        <= '0;
          err        <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/field_unit_arbiter.md
Name: field_unit_arbiter

Overview:
Round-robin arbiter that shares one edge-triggered two-operand field unit (field_mux, add, sub or mul style: start on rising en, completion on ready_pulse) among NREQ requesters. It latches the winning requester's operands, drives the unit's en, and waits for the unit's ready_pulse. It then returns the result with a one-hot done pulse. Sits between gate/layer sequencers and a single shared arithmetic unit to save area.

Parameters:
NREQ, 4, number of requesters (2..16)
TIMEOUT, 255, BUSY-state watchdog limit in cycles (used only with FIELD_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rstb  in  1  asynchronous active-low reset
req  in  NREQ  level request per requester
a_in  in  NREQ*F_NBITS  operand a, requester i at [i*F_NBITS +: F_NBITS]
b_in  in  NREQ*F_NBITS  operand b, same packing
gnt  out  NREQ  one-hot grant, held from issue through DONE
done_pulse  out  NREQ  one-hot, 1-cycle completion strobe
c  out  F_NBITS  result register
busy  out  1  high in BUSY and DONE
err  out  1  timeout flag (tied 0 without the macro)
unit_en  out  1  en to the shared unit (registered)
unit_a  out  F_NBITS  latched operand a
unit_b  out  F_NBITS  latched operand b
unit_ready_pulse  in  1  unit completion strobe
unit_c  in  F_NBITS  unit result

Behaviour:
- Widths: F_NBITS comes from field_arith_defs. No arithmetic here; operands and results pass through unmodified.
- Reset values: state=IDLE, gnt=0, done_pulse=0, c=0, busy=0, err=0, unit_en=0, unit_a=0, unit_b=0, rr pointer=0. The reset is async and may arrive at any point, including mid-operation: the in-flight op is dropped and unit_en falls immediately.
- States: IDLE, BUSY, DONE (registered FSM).
- IDLE:
  - unit_en=0.
  - If any req is set, pick the first set bit scanning from ptr, ptr+1, ..., wrapping modulo NREQ.
  - At that edge: latch a_in/b_in slices into unit_a/unit_b, set gnt one-hot, set unit_en=1, go to BUSY, set ptr = winner+1 mod NREQ.
  - If req is all zero, stay in IDLE.
  - unit_ready_pulse is ignored in IDLE.
- BUSY:
  - unit_en held at 1, operands held.
  - On unit_ready_pulse: capture unit_c into c, assert done_pulse[winner] for the next cycle, clear unit_en, go to DONE.
- DONE:
  - Lasts exactly one cycle. done_pulse is valid, c is valid, gnt is still asserted.
  - Then gnt clears and the FSM returns to IDLE.
  - c holds its value until the next capture.
- Minimum en-low gap: unit_en is low for at least 2 cycles between ops (DONE, IDLE), which guarantees the unit sees a fresh rising edge.
- Latency: req sampled at edge 0 → unit_en=1 after edge 0 → mux-type unit gives ready_pulse the next cycle → done_pulse/c valid after edge 2. Total is 3 cycles for a 1-cycle unit and N+2 cycles for an N-cycle unit.
- Requester contract:
  - Hold req and the operands stable until gnt is seen; operands may change after the grant edge.
  - Deassert req no later than the edge ending the done_pulse cycle. A req still high in IDLE is a new request.
- Simultaneous requests are resolved purely by the rr pointer. Under continuous contention, no requester waits more than NREQ-1 ops.
- A req arriving while BUSY waits; it is evaluated in the next IDLE.

Optional Feature:
FIELD_ARB_TIMEOUT_EN:
- Defined: an 8..16-bit counter clears on entering BUSY and increments each BUSY cycle. If it reaches TIMEOUT without unit_ready_pulse, the arbiter enters DONE with done_pulse[winner], leaves c unchanged, and sets err=1 for that DONE cycle only. unit_en drops as normal.
- Undefined: no counter, err is constant 0, and BUSY waits indefinitely.

Test Plan:
- Reset, then req=4'b0001, a=5, b=9, with a field_mux-behaving model (sel=1): done_pulse=4'b0001 exactly 3 cycles after req is sampled, c=9, unit_en is high for exactly 2 cycles.
- req=4'b1111 held, distinct operands, each requester dropping req on its done: grants in order 0,1,2,3; each done_pulse matches its gnt; c equals each requester's operand selection.
- After a grant to 2, req=4'b0101: next grant goes to 0 (wrap from ptr=3), not 2.
- Unit model with a 5-cycle delay: done_pulse arrives 7 cycles after req; unit_en stays low at least 2 cycles between consecutive ops; a spurious unit_ready_pulse injected in IDLE causes no done_pulse.
- Assert rstb=0 mid-BUSY: all outputs go to 0 asynchronously; after release, req=4'b0010 is granted to requester 1 with ptr reset behaviour (requester 0 has priority if also requesting).
- With FIELD_ARB_TIMEOUT_EN and TIMEOUT=10, the unit never pulses: done_pulse and err=1 appear after BUSY has lasted 10 cycles; c keeps its previous value; without the macro, busy stays high.
